// File: rtl/adder_sched_pkg.sv
// Shared types and helpers for the adder scheduler.
// Provides the FSM state enum, counter width and an index-width helper.
package adder_sched_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    RESP
  } state_t;

  localparam int OP_CNT_W = 16;

  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/adder_sched_rr_arbiter.sv
// Combinational round-robin arbiter; search starts at ptr and wraps.
// Ports: req, ptr, enable in; one-hot grant, grant_idx, any_grant out.
module rr_arbiter
  import adder_sched_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int ID_W  = id_width(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  input  logic             enable,
  output logic [N_REQ-1:0] grant,
  output logic [ID_W-1:0]  grant_idx,
  output logic             any_grant
);

  always_comb begin
    int j;
    j         = 0;
    grant     = '0;
    grant_idx = '0;
    any_grant = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      j = (int'(ptr) + k) % N_REQ;
      if (enable && !any_grant && req[j]) begin
        any_grant = 1'b1;
        grant[j]  = 1'b1;
        grant_idx = ID_W'(j);
      end
    end
  end

endmodule

// File: rtl/adder_sched.sv
// Time-shares one external ripple adder between N_REQ requesters.
// Ports: req valid/ready/a/b, adder_a/b/sum, resp valid/ready/sum/id/carry, busy, op_count.
module adder_sched
  import adder_sched_pkg::*;
#(
  parameter int DATA_WIDTH    = 8,
  parameter int N_REQ         = 4,
  parameter int SETTLE_CYCLES = 2,
  parameter int ID_W          = id_width(N_REQ)
) (
  input  logic                        clk,
  input  logic                        resetn,
  input  logic [N_REQ-1:0]            req_valid,
  output logic [N_REQ-1:0]            req_ready,
  input  logic [N_REQ*DATA_WIDTH-1:0] req_a,
  input  logic [N_REQ*DATA_WIDTH-1:0] req_b,
  output logic [DATA_WIDTH-1:0]       adder_a,
  output logic [DATA_WIDTH-1:0]       adder_b,
  input  logic [DATA_WIDTH:0]         adder_sum,
  output logic                        resp_valid,
  input  logic                        resp_ready,
  output logic [DATA_WIDTH:0]         resp_sum,
  output logic [ID_W-1:0]             resp_id,
  output logic                        resp_carry,
  output logic                        busy,
  output logic [OP_CNT_W-1:0]         op_count
);

  localparam int CW = id_width(SETTLE_CYCLES);

  state_t           state;
  state_t           state_n;
  logic [ID_W-1:0]  ptr;
  logic [CW-1:0]    cnt;
  logic [N_REQ-1:0] grant;
  logic [ID_W-1:0]  gidx;
  logic             any;
  logic             arb_en;

  // Gate with resetn so req_ready stays low while reset is held.
  assign arb_en = resetn && (state == IDLE);

  rr_arbiter #(
    .N_REQ(N_REQ),
    .ID_W (ID_W)
  ) u_arb (
    .req      (req_valid),
    .ptr      (ptr),
    .enable   (arb_en),
    .grant    (grant),
    .grant_idx(gidx),
    .any_grant(any)
  );

  assign req_ready  = grant;
  assign busy       = (state != IDLE);
  assign resp_carry = resp_sum[DATA_WIDTH];

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (any) state_n = SETTLE;
      SETTLE:  if (cnt == '0) state_n = RESP;
      RESP:    if (resp_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ptr        <= '0;
      cnt        <= '0;
      adder_a    <= '0;
      adder_b    <= '0;
      resp_valid <= 1'b0;
      resp_sum   <= '0;
      resp_id    <= '0;
      op_count   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (any) begin
            adder_a <= req_a[int'(gidx)*DATA_WIDTH +: DATA_WIDTH];
            adder_b <= req_b[int'(gidx)*DATA_WIDTH +: DATA_WIDTH];
            resp_id <= gidx;
            cnt     <= CW'(SETTLE_CYCLES - 1);
          end
        end
        SETTLE: begin
          if (cnt == '0) begin
            resp_sum   <= adder_sum;
            resp_valid <= 1'b1;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            op_count   <= op_count + OP_CNT_W'(1);
            ptr        <= (resp_id == ID_W'(N_REQ - 1)) ?
                          '0 : resp_id + ID_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_adder_sched.sv
// Directed bench for adder_sched with a queue scoreboard.
// Drives requests, models the shared adder, checks responses and arbitration.
module tb_adder_sched;

  localparam int DW = 8;
  localparam int NR = 4;

  typedef struct packed {
    logic [1:0] id;
    logic [8:0] sum;
  } sb_t;

  logic          clk;
  logic          resetn;
  logic [NR-1:0] req_valid;
  logic [NR-1:0] req_ready;
  logic [31:0]   req_a;
  logic [31:0]   req_b;
  logic [7:0]    adder_a;
  logic [7:0]    adder_b;
  logic [8:0]    adder_sum;
  logic          resp_valid;
  logic          resp_ready;
  logic [8:0]    resp_sum;
  logic [1:0]    resp_id;
  logic          resp_carry;
  logic          busy;
  logic [15:0]   op_count;

  logic [7:0] op_a [NR];
  logic [7:0] op_b [NR];

  sb_t sb   [$];
  int  glog [$];
  int  gcyc [$];
  int  cyc;
  int  checks;
  int  failures;

  adder_sched dut (
    .clk       (clk),
    .resetn    (resetn),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .adder_a   (adder_a),
    .adder_b   (adder_b),
    .adder_sum (adder_sum),
    .resp_valid(resp_valid),
    .resp_ready(resp_ready),
    .resp_sum  (resp_sum),
    .resp_id   (resp_id),
    .resp_carry(resp_carry),
    .busy      (busy),
    .op_count  (op_count)
  );

  // Shared adder living at the parent level.
  assign adder_sum = {1'b0, adder_a} + {1'b0, adder_b};

  always_comb begin
    req_a = '0;
    req_b = '0;
    for (int i = 0; i < NR; i++) begin
      req_a[i*DW +: DW] = op_a[i];
      req_b[i*DW +: DW] = op_b[i];
    end
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Sample handshakes just before the edge, then advance one cycle.
  task automatic tick();
    sb_t e;
    #1;
    for (int i = 0; i < NR; i++) begin
      if (req_valid[i] && req_ready[i]) begin
        e.id  = 2'(i);
        e.sum = {1'b0, op_a[i]} + {1'b0, op_b[i]};
        sb.push_back(e);
        glog.push_back(i);
        gcyc.push_back(cyc);
      end
    end
    if (resp_valid && resp_ready) begin
      if (sb.size() == 0) begin
        chk("sb_underflow", 32'(resp_valid), 32'(0));
      end else begin
        e = sb.pop_front();
        chk("sb_id", 32'(resp_id), 32'(e.id));
        chk("sb_sum", 32'(resp_sum), 32'(e.sum));
      end
    end
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic drain();
    for (int k = 0; k < 30 && (busy || resp_valid); k++) tick();
    chk("drain_idle", 32'(busy), 32'(0));
    chk("drain_sb_empty", 32'(sb.size()), 32'(0));
  endtask

  initial begin
    checks     = 0;
    failures   = 0;
    cyc        = 0;
    resetn     = 1'b0;
    resp_ready = 1'b1;
    req_valid  = '1;
    op_a[0] = 8'hFF; op_b[0] = 8'hFF;
    op_a[1] = 8'h12; op_b[1] = 8'h34;
    op_a[2] = 8'hFF; op_b[2] = 8'h01;
    op_a[3] = 8'h00; op_b[3] = 8'h00;

    // Reset held 3 cycles with all requests asserted.
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("rst_req_ready", 32'(req_ready), 32'(0));
    end
    chk("rst_outs", 32'({resp_valid, resp_sum, resp_id, busy, adder_a, adder_b}),
        32'(0));
    chk("rst_opcnt", 32'(op_count), 32'(0));
    req_valid = '0;
    resetn    = 1'b1;
    tick();
    chk("idle_busy", 32'(busy), 32'(0));
    chk("idle_ready", 32'(req_ready), 32'(0));

    // Single op from requester 2: 0xFF + 0x01.
    req_valid = 4'b0100;
    #1;
    chk("single_ready", 32'(req_ready), 32'(4'b0100));
    tick();
    req_valid = '0;
    op_a[2]   = 8'h55;
    chk("single_adder", 32'({adder_a, adder_b}), 32'(16'hFF01));
    chk("single_busy", 32'(busy), 32'(1));
    tick();
    chk("single_lat1", 32'(resp_valid), 32'(0));
    tick();
    chk("single_lat2", 32'(resp_valid), 32'(1));
    chk("single_resp", 32'({resp_carry, resp_id, resp_sum}),
        32'({1'b1, 2'd2, 9'h100}));
    tick();
    chk("single_opcnt", 32'(op_count), 32'(1));
    chk("single_sb", 32'(sb.size()), 32'(0));
    op_a[2] = 8'h7F;

    // Round robin from ptr 0 with everyone requesting.
    resetn = 1'b0;
    #1;
    resetn = 1'b1;
    glog.delete();
    gcyc.delete();
    req_valid = '1;
    for (int k = 0; k < 40 && glog.size() < 5; k++) tick();
    req_valid = '0;
    chk("rr_count", 32'(glog.size()), 32'(5));
    if (glog.size() == 5) begin
      for (int k = 0; k < 5; k++) chk("rr_order", 32'(glog[k]), 32'(k % NR));
      for (int k = 0; k < 4; k++)
        chk("rr_spacing", 32'(gcyc[k+1] - gcyc[k]), 32'(4));
    end
    drain();

    // Backpressure: requester 1 stalls in RESP, others wait.
    resp_ready = 1'b0;
    req_valid  = 4'b0010;
    tick();
    req_valid = '1;
    for (int k = 0; k < 10 && !resp_valid; k++) tick();
    chk("bp_valid", 32'(resp_valid), 32'(1));
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("bp_hold", 32'({resp_valid, req_ready, resp_id, resp_sum}),
          32'({1'b1, 4'b0000, 2'd1, 9'h046}));
    end
    resp_ready = 1'b1;
    tick();
    chk("bp_idle", 32'(busy), 32'(0));
    chk("bp_next_ready", 32'(req_ready), 32'(4'b0100));
    tick();
    req_valid = '0;
    chk("bp_next_grant", 32'(glog[$]), 32'(2));
    drain();

    // Reset during SETTLE drops the op.
    op_a[3]   = 8'h12;
    op_b[3]   = 8'h34;
    req_valid = 4'b0001;
    tick();
    req_valid = '0;
    chk("mid_busy_pre", 32'(busy), 32'(1));
    #3;
    resetn = 1'b0;
    #1;
    chk("mid_async", 32'({busy, resp_valid, adder_a, adder_b, resp_id}), 32'(0));
    sb.delete();
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("mid_no_resp", 32'(resp_valid), 32'(0));
    resetn    = 1'b1;
    req_valid = '1;
    #1;
    chk("mid_ptr0", 32'(req_ready), 32'(4'b0001));
    req_valid = 4'b1000;
    tick();
    req_valid = '0;
    for (int k = 0; k < 10 && !resp_valid; k++) tick();
    chk("mid_resp", 32'({resp_valid, resp_id, resp_sum}),
        32'({1'b1, 2'd3, 9'h046}));
    drain();
    chk("mid_opcnt", 32'(op_count), 32'(1));

    // op_count wrap from a preloaded 0xFFFF.
    force dut.op_count = 16'hFFFF;
    #1;
    release dut.op_count;
    #1;
    chk("wrap_pre", 32'(op_count), 32'(16'hFFFF));
    req_valid = 4'b0001;
    tick();
    req_valid = '0;
    drain();
    chk("wrap_post", 32'(op_count), 32'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
